// File: rtl/player_ctrl_if.sv
// Player-car control bundle: frame strobe and driver inputs in, car pose and status out.
// The slave side is the controller; the master side is the game logic driving it.
interface player_ctrl_if #(
    parameter int unsigned X_W   = 8,
    parameter int unsigned Y_W   = 10,
    parameter int unsigned SPD_W = 3
);
    logic             tick;
    logic             left;
    logic             right;
    logic             accel;
    logic             crash;
    logic [X_W-1:0]   car_x;
    logic [Y_W-1:0]   car_y;
    logic [SPD_W-1:0] speed;
    logic             alive;
    logic             respawning;
    logic [3:0]       crash_count;

    modport slave (
        input  tick, left, right, accel, crash,
        output car_x, car_y, speed, alive, respawning, crash_count
    );

    modport master (
        output tick, left, right, accel, crash,
        input  car_x, car_y, speed, alive, respawning, crash_count
    );
endinterface

// File: rtl/player_ctrl.sv
// Player-car controller: steering and speed on frame ticks, plus a
// drive / skid / respawn state machine driven by collisions.
module player_ctrl #(
    parameter int unsigned X_W           = 8,
    parameter int unsigned Y_W           = 10,
    parameter int unsigned TRACK_WIDTH   = 255,
    parameter int unsigned CAR_WIDTH     = 16,
    parameter int unsigned START_X       = 128,
    parameter int unsigned CAR_Y         = 440,
    parameter int unsigned STEP          = 1,
    parameter int unsigned MAX_SPEED     = 7,
    parameter int unsigned WALL_KILL     = 0,
    parameter int unsigned SKID_TICKS    = 16,
    parameter int unsigned RESPAWN_TICKS = 32
) (
    input logic            clk,
    input logic            reset,
    player_ctrl_if.slave   bus
);
    localparam int unsigned SPD_W   = $clog2(MAX_SPEED + 1);
    localparam int unsigned TMR_MAX = (SKID_TICKS > RESPAWN_TICKS) ? SKID_TICKS : RESPAWN_TICKS;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [X_W-1:0]   XMAX    = X_W'(TRACK_WIDTH - CAR_WIDTH);
    localparam logic [X_W-1:0]   X_START = X_W'(START_X - CAR_WIDTH / 2);
    localparam logic [X_W-1:0]   X_STEP  = X_W'(STEP);
    localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(MAX_SPEED);

    typedef enum logic [1:0] {StDrive, StSkid, StRespawn} state_e;

    state_e           state_q, state_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [SPD_W-1:0] speed_q, speed_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [3:0]       count_q, count_d;
    logic             dir_right_q, dir_right_d;

    logic             steer_l, steer_r, wall_hit;
    logic [X_W-1:0]   x_left, x_right;
    logic [X_W:0]     x_plus;
    logic [SPD_W-1:0] speed_next;

    assign steer_l = bus.left & ~bus.right;
    assign steer_r = bus.right & ~bus.left;

    // Right-edge test uses one extra bit so x+STEP cannot wrap past XMAX.
    assign x_plus  = {1'b0, x_q} + {1'b0, X_STEP};
    assign x_right = (x_plus <= {1'b0, XMAX}) ? x_plus[X_W-1:0] : XMAX;
    assign x_left  = (x_q >= X_STEP) ? (x_q - X_STEP) : '0;

    assign wall_hit = (WALL_KILL != 0) &&
                      ((steer_l && (x_q == '0)) || (steer_r && (x_q == XMAX)));

    always_comb begin
        speed_next = speed_q;
        if (bus.accel) begin
            if (speed_q != SPD_MAX) speed_next = speed_q + SPD_W'(1);
        end else begin
            if (speed_q != '0) speed_next = speed_q - SPD_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        speed_d     = speed_q;
        timer_d     = timer_q;
        count_d     = count_q;
        dir_right_d = dir_right_q;

        unique case (state_q)
            StDrive: begin
                // A crash on a tick cycle discards that tick's move and speed update.
                if (bus.crash || (bus.tick && wall_hit)) begin
                    state_d = StSkid;
                    speed_d = '0;
                    timer_d = TMR_W'(SKID_TICKS);
                    if (count_q != 4'hF) count_d = count_q + 4'd1;
                end else if (bus.tick) begin
                    if (steer_l) begin
                        x_d         = x_left;
                        dir_right_d = 1'b0;
                    end else if (steer_r) begin
                        x_d         = x_right;
                        dir_right_d = 1'b1;
                    end
                    speed_d = speed_next;
                end
            end
            StSkid: begin
                if (bus.tick) begin
                    x_d     = dir_right_q ? x_right : x_left;
                    timer_d = timer_q - TMR_W'(1);
                    if (timer_q == TMR_W'(1)) begin
                        state_d = StRespawn;
                        x_d     = X_START;
                        speed_d = '0;
                        timer_d = TMR_W'(RESPAWN_TICKS);
                    end
                end
            end
            StRespawn: begin
                if (bus.tick) begin
                    if (steer_l) begin
                        x_d         = x_left;
                        dir_right_d = 1'b0;
                    end else if (steer_r) begin
                        x_d         = x_right;
                        dir_right_d = 1'b1;
                    end
                    speed_d = speed_next;
                    timer_d = timer_q - TMR_W'(1);
                    if (timer_q == TMR_W'(1)) state_d = StDrive;
                end
            end
            default: state_d = StDrive;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StDrive;
            x_q         <= X_START;
            speed_q     <= '0;
            timer_q     <= '0;
            count_q     <= '0;
            dir_right_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            speed_q     <= speed_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
            dir_right_q <= dir_right_d;
        end
    end

    assign bus.car_x       = x_q;
    assign bus.car_y       = Y_W'(CAR_Y);
    assign bus.speed       = speed_q;
    assign bus.alive       = (state_q != StSkid);
    assign bus.respawning  = (state_q == StRespawn);
    assign bus.crash_count = count_q;
endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl: one instance without and one with wall kill,
// driven on the falling edge and sampled on the falling edge.
module tb_player_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    player_ctrl_if #(.X_W(8), .Y_W(10), .SPD_W(3)) ifa ();
    player_ctrl_if #(.X_W(8), .Y_W(10), .SPD_W(3)) ifb ();

    player_ctrl #(.WALL_KILL(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    player_ctrl #(.WALL_KILL(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One-cycle tick strobe on both instances per frame; outputs settle by the next negedge.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ifa.tick = 1'b1;
            ifb.tick = 1'b1;
            @(negedge clk);
            ifa.tick = 1'b0;
            ifb.tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic set_a(input logic l, input logic r, input logic acc);
        ifa.left  = l;
        ifa.right = r;
        ifa.accel = acc;
    endtask

    initial begin
        {ifa.tick, ifa.left, ifa.right, ifa.accel, ifa.crash} = '0;
        {ifb.tick, ifb.left, ifb.right, ifb.accel, ifb.crash} = '0;

        // 1: reset values, then idle ticks
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(ifa.car_x), 120);
        chk("rst_alive", 32'(ifa.alive), 1);
        chk("rst_y", 32'(ifa.car_y), 440);
        reset = 1'b1;
        @(negedge clk);
        ticks(10);
        chk("idle_x", 32'(ifa.car_x), 120);
        chk("idle_speed", 32'(ifa.speed), 0);
        chk("idle_alive", 32'(ifa.alive), 1);
        chk("idle_count", 32'(ifa.crash_count), 0);
        chk("idle_resp", 32'(ifa.respawning), 0);

        // 2: right edge saturation without wall kill, both keys hold x
        set_a(1'b0, 1'b1, 1'b0);
        ticks(10);
        chk("right10_x", 32'(ifa.car_x), 130);
        ticks(190);
        chk("right_sat_x", 32'(ifa.car_x), 239);
        chk("right_sat_alive", 32'(ifa.alive), 1);
        chk("right_sat_count", 32'(ifa.crash_count), 0);
        set_a(1'b1, 1'b1, 1'b0);
        ticks(5);
        chk("both_x", 32'(ifa.car_x), 239);

        // 3: speed ramp, decay, and hold without tick
        set_a(1'b0, 1'b0, 1'b1);
        ticks(3);
        chk("accel3_speed", 32'(ifa.speed), 3);
        ticks(7);
        chk("accel_max_speed", 32'(ifa.speed), 7);
        set_a(1'b0, 1'b0, 1'b0);
        ticks(3);
        chk("decay_speed", 32'(ifa.speed), 4);
        set_a(1'b1, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("notick_speed", 32'(ifa.speed), 4);
        chk("notick_x", 32'(ifa.car_x), 239);

        // 4: crash on a tick cycle, skid drift, respawn immunity
        ticks(10);
        chk("pre_left_x", 32'(ifa.car_x), 229);
        chk("pre_speed", 32'(ifa.speed), 7);
        set_a(1'b0, 1'b1, 1'b1);
        ticks(1);
        chk("pre_right_x", 32'(ifa.car_x), 230);
        ifa.tick  = 1'b1;
        ifa.crash = 1'b1;
        @(negedge clk);
        ifa.tick  = 1'b0;
        ifa.crash = 1'b0;
        chk("crash_alive", 32'(ifa.alive), 0);
        chk("crash_speed", 32'(ifa.speed), 0);
        chk("crash_count", 32'(ifa.crash_count), 1);
        chk("crash_x", 32'(ifa.car_x), 230);
        @(negedge clk);
        ticks(8);
        chk("skid8_x", 32'(ifa.car_x), 238);
        chk("skid8_speed", 32'(ifa.speed), 0);
        set_a(1'b0, 1'b0, 1'b0);
        ticks(7);
        chk("skid15_alive", 32'(ifa.alive), 0);
        ticks(1);
        chk("resp_x", 32'(ifa.car_x), 120);
        chk("resp_flag", 32'(ifa.respawning), 1);
        chk("resp_alive", 32'(ifa.alive), 1);
        ifa.crash = 1'b1;
        @(negedge clk);
        ifa.crash = 1'b0;
        @(negedge clk);
        chk("resp_crash_count", 32'(ifa.crash_count), 1);
        chk("resp_crash_alive", 32'(ifa.alive), 1);
        ticks(31);
        chk("resp31_flag", 32'(ifa.respawning), 1);
        ticks(1);
        chk("resp_done_flag", 32'(ifa.respawning), 0);
        chk("resp_done_x", 32'(ifa.car_x), 120);

        // 5: wall kill on the left edge
        ifb.left = 1'b1;
        ticks(120);
        chk("wk_edge_x", 32'(ifb.car_x), 0);
        chk("wk_edge_alive", 32'(ifb.alive), 1);
        ticks(1);
        chk("wk_alive", 32'(ifb.alive), 0);
        chk("wk_count", 32'(ifb.crash_count), 1);
        chk("wk_x", 32'(ifb.car_x), 0);
        ifb.left = 1'b0;

        // 6: asynchronous reset in the middle of a skid
        ifa.crash = 1'b1;
        @(negedge clk);
        ifa.crash = 1'b0;
        chk("nt_crash_alive", 32'(ifa.alive), 0);
        chk("nt_crash_count", 32'(ifa.crash_count), 2);
        ticks(11);
        chk("mid_skid_alive", 32'(ifa.alive), 0);
        #2 reset = 1'b0;
        #1;
        chk("arst_x", 32'(ifa.car_x), 120);
        chk("arst_alive", 32'(ifa.alive), 1);
        chk("arst_count", 32'(ifa.crash_count), 0);
        chk("arst_speed", 32'(ifa.speed), 0);
        chk("arst_resp", 32'(ifa.respawning), 0);
        chk("arst_b_count", 32'(ifb.crash_count), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        set_a(1'b0, 1'b1, 1'b0);
        ticks(1);
        chk("post_x", 32'(ifa.car_x), 121);
        chk("post_alive", 32'(ifa.alive), 1);
        set_a(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
